axi_master_arbiter: RTL

- Round-robin arbiter sharing one simple AXI master's internal bus (addr/wdata/wsize/rw/rdata/wait/done/clear_done/invalid/error) between N requesters.
- Accepts one request at a time over a valid/ready handshake and sequences the master's level-based protocol: issue, wait, capture, clear done.
- Returns a one-cycle response pulse to the granted requester.
- Sits between CPU/DMA-side clients and the AXI master.

---
 rtl/axi_master_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_master_arbiter.sv
// Round-robin arbiter sharing one simple AXI master between N requesters.
// Sequences the master's level protocol: issue, wait for done, respond, clear done.
module axi_master_arbiter #(
    parameter  int unsigned N   = 2,
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N-1:0]      i_req_valid,
    output logic [N-1:0]      o_req_ready,
    input  logic [2*N-1:0]    i_req_rw,
    input  logic [32*N-1:0]   i_req_addr,
    input  logic [64*N-1:0]   i_req_wdata,
    input  logic [3*N-1:0]    i_req_wsize,
    output logic [N-1:0]      o_resp_valid,
    output logic [63:0]       o_resp_rdata,
    output logic              o_resp_error,
    output logic              o_resp_invalid,
    output logic              o_busy,
    output logic [IDW-1:0]    o_grant_id,
    output logic [31:0]       o_m_addr,
    output logic [63:0]       o_m_wdata,
    output logic [2:0]        o_m_wsize,
    output logic [1:0]        o_m_rw,
    input  logic [63:0]       i_m_rdata,
    input  logic              i_m_wait,
    input  logic              i_m_done,
    input  logic              i_m_invalid,
    input  logic              i_m_error,
    output logic              o_m_clear_done
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 3;
    localparam int unsigned RW = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [IDW-1:0]  r_last, w_last_nxt;
    logic [IDW-1:0]  r_grant, w_grant_nxt;
    logic [RW-1:0]   r_rw, w_rw_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;
    logic [SW-1:0]   r_wsize, w_wsize_nxt;
    logic            r_reject, w_reject_nxt;
    logic [RW-1:0]   r_m_rw, w_m_rw_nxt;
    logic [N-1:0]    r_resp_valid, w_resp_valid_nxt;
    logic            r_resp_error, w_resp_error_nxt;
    logic            r_resp_invalid, w_resp_invalid_nxt;
    logic [DW-1:0]   r_resp_rdata, w_resp_rdata_nxt;

    logic [N-1:0]    w_req_ready;
    logic            w_clear_done;
    logic            w_m_idle;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW-1:0]  w_idx;
    logic [RW-1:0]   w_sel_rw;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic [SW-1:0]   w_sel_wsize;

    assign w_m_idle    = !i_m_wait && !i_m_done;
    assign w_sel_rw    = i_req_rw[int'(w_win)*2 +: 2];
    assign w_sel_addr  = i_req_addr[int'(w_win)*32 +: 32];
    assign w_sel_wdata = i_req_wdata[int'(w_win)*64 +: 64];
    assign w_sel_wsize = i_req_wsize[int'(w_win)*3 +: 3];

    // Round-robin scan starting just after the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            w_idx = IDW'((int'(r_last) + i) % int'(N));
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_last_nxt         = r_last;
        w_grant_nxt        = r_grant;
        w_rw_nxt           = r_rw;
        w_addr_nxt         = r_addr;
        w_wdata_nxt        = r_wdata;
        w_wsize_nxt        = r_wsize;
        w_reject_nxt       = r_reject;
        w_m_rw_nxt         = 2'b00;
        w_resp_valid_nxt   = '0;
        w_resp_error_nxt   = 1'b0;
        w_resp_invalid_nxt = 1'b0;
        w_resp_rdata_nxt   = r_resp_rdata;
        w_req_ready        = '0;
        w_clear_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_m_idle) begin
                    // Stale completion left over from before a reset: drop it.
                    w_clear_done = i_m_done && !i_m_wait;
                end else if (w_found) begin
                    w_req_ready[w_win] = 1'b1;
                    w_last_nxt         = w_win;
                    w_grant_nxt        = w_win;
                    w_rw_nxt           = w_sel_rw;
                    w_addr_nxt         = w_sel_addr;
                    w_wdata_nxt        = w_sel_wdata;
                    w_wsize_nxt        = w_sel_wsize;
                    if (w_sel_rw == 2'b01 || w_sel_rw == 2'b10) begin
                        w_state_nxt  = S_ISSUE;
                        w_m_rw_nxt   = w_sel_rw;
                        w_reject_nxt = 1'b0;
                    end else begin
                        w_state_nxt               = S_RESP;
                        w_reject_nxt              = 1'b1;
                        w_resp_valid_nxt[w_win]   = 1'b1;
                        w_resp_error_nxt          = 1'b1;
                        w_resp_invalid_nxt        = 1'b1;
                        w_resp_rdata_nxt          = '0;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (i_m_done && !i_m_wait) begin
                    w_state_nxt               = S_RESP;
                    w_resp_valid_nxt[r_grant] = 1'b1;
                    w_resp_error_nxt          = i_m_error;
                    w_resp_invalid_nxt        = i_m_invalid;
                    w_resp_rdata_nxt          = (r_rw == 2'b10) ? i_m_rdata : '0;
                end
            end
            S_RESP: begin
                w_clear_done = !r_reject;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_last         <= IDW'(N - 1);
            r_grant        <= '0;
            r_rw           <= '0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wsize        <= '0;
            r_reject       <= 1'b0;
            r_m_rw         <= '0;
            r_resp_valid   <= '0;
            r_resp_error   <= 1'b0;
            r_resp_invalid <= 1'b0;
            r_resp_rdata   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_last         <= w_last_nxt;
            r_grant        <= w_grant_nxt;
            r_rw           <= w_rw_nxt;
            r_addr         <= w_addr_nxt;
            r_wdata        <= w_wdata_nxt;
            r_wsize        <= w_wsize_nxt;
            r_reject       <= w_reject_nxt;
            r_m_rw         <= w_m_rw_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_error   <= w_resp_error_nxt;
            r_resp_invalid <= w_resp_invalid_nxt;
            r_resp_rdata   <= w_resp_rdata_nxt;
        end
    end

    // Combinational strobes are forced low while reset is asserted.
    assign o_req_ready    = w_req_ready & {N{i_rst_n}};
    assign o_m_clear_done = w_clear_done & i_rst_n;
    assign o_busy         = (r_state != S_IDLE);
    assign o_grant_id     = r_grant;
    assign o_m_addr       = r_addr;
    assign o_m_wdata      = r_wdata;
    assign o_m_wsize      = r_wsize;
    assign o_m_rw         = r_m_rw;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_rdata   = r_resp_rdata;
    assign o_resp_error   = r_resp_error;
    assign o_resp_invalid = r_resp_invalid;

endmodule
